// File: rtl/prog_loader_pkg.sv
// ============================================================================
// Package : prog_loader_pkg
// Brief   : Shared constants and state encoding for the program loader.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int COUNT_WIDTH    = 16;
    localparam int STATE_WIDTH    = 3;

    typedef logic [STATE_WIDTH-1:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_HDR_HI = 3'd1;
    localparam state_t S_HDR_LO = 3'd2;
    localparam state_t S_DATA   = 3'd3;
    localparam state_t S_CHK    = 3'd4;
    localparam state_t S_DONE   = 3'd5;
    localparam state_t S_ERR    = 3'd6;

    // True while a frame is being received (CPU must be held)
    function automatic logic is_loading(input state_t s);
        return (s == S_HDR_HI) || (s == S_HDR_LO) || (s == S_DATA) || (s == S_CHK);
    endfunction

endpackage

`default_nettype wire

// File: rtl/prog_loader_word_asm.sv
// ============================================================================
// Module  : prog_loader_word_asm
// Brief   : Shifts bytes into a big-endian word and strobes when a word is
//           complete. o_word_done marks the 4th byte as it is accepted;
//           o_word_valid is the registered strobe one cycle later, when
//           o_word holds the assembled word.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader_word_asm
    import prog_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_byte_valid,
    input  logic [7:0]            i_byte_data,
    output logic                  o_word_done,
    output logic                  o_word_valid,
    output logic [DATA_WIDTH-1:0] o_word
);

    localparam int              CNT_W  = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(BYTES_PER_WORD - 1);

    logic [CNT_W-1:0]      r_cnt;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  w_last;

    assign w_last       = i_byte_valid && (r_cnt == c_LAST);
    assign o_word_done  = w_last;
    assign o_word_valid = r_valid;
    assign o_word       = r_word;

    // Byte counter, shift register (new byte enters at the LSB end) and strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_word  <= '0;
        end else begin
            r_valid <= w_last && !i_clr;
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_byte_valid) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (i_byte_valid) begin
                r_word <= {r_word[DATA_WIDTH-9:0], i_byte_data};
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module  : prog_loader
// Brief   : UART byte-stream program loader. Parses a 16-bit big-endian word
//           count header, assembles 32-bit big-endian words and writes them to
//           program RAM from address 0 upward while holding the CPU in reset.
// Options : define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum
//           byte covering every header and data byte.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_hold
);

    localparam int                     TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]       c_TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] c_MAX_WORDS = COUNT_WIDTH'(2 ** ADDR_WIDTH);
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t                 c_END_STATE = S_CHK;
`else
    localparam state_t                 c_END_STATE = S_DONE;
`endif

    state_t                 r_state;
    state_t                 w_next;
    logic [7:0]             r_hdr_hi;
    logic [ADDR_WIDTH-1:0]  r_widx;
    logic [ADDR_WIDTH-1:0]  r_last_idx;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [TMO_W-1:0]       r_tmo;
    logic [COUNT_WIDTH-1:0] w_count;
    logic                   w_busy;
    logic                   w_launch;
    logic                   w_tmo_hit;
    logic                   w_data_byte;
    logic                   w_word_done;
    logic                   w_word_valid;
    logic [DATA_WIDTH-1:0]  w_word;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]             r_xsum;
`endif

    assign w_count     = {r_hdr_hi, rx_data};
    assign w_busy      = is_loading(r_state);
    assign w_launch    = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign w_tmo_hit   = w_busy && !rx_valid && (r_tmo == c_TMO_LAST);
    assign w_data_byte = (r_state == S_DATA) && rx_valid;

    prog_loader_word_asm #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_word_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (w_launch),
        .i_byte_valid (w_data_byte),
        .i_byte_data  (rx_data),
        .o_word_done  (w_word_done),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; the frame ends as the last data byte is accepted, so
    // its RAM write lands in the following cycle alongside a possible
    // checksum byte.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_next = S_HDR_HI;
            end
            S_HDR_HI: begin
                if (rx_valid) w_next = S_HDR_LO;
            end
            S_HDR_LO: begin
                if (rx_valid) begin
                    if (w_count > c_MAX_WORDS) begin
                        w_next = S_ERR;
                    end else if (w_count == '0) begin
                        w_next = c_END_STATE;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_word_done && (r_widx == r_last_idx)) w_next = c_END_STATE;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (rx_valid) w_next = (rx_data == r_xsum) ? S_DONE : S_ERR;
            end
`endif
            default: w_next = S_IDLE;
        endcase
        if (w_tmo_hit) w_next = S_ERR;
    end

    // Header capture, word index, write address and inter-byte timeout
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hdr_hi   <= '0;
            r_widx     <= '0;
            r_last_idx <= '0;
            r_addr     <= '0;
            r_tmo      <= '0;
        end else if (w_launch) begin
            r_widx <= '0;
            r_tmo  <= '0;
        end else begin
            if (w_busy) begin
                r_tmo <= rx_valid ? '0 : r_tmo + TMO_W'(1);
            end
            if ((r_state == S_HDR_HI) && rx_valid) begin
                r_hdr_hi <= rx_data;
            end
            if ((r_state == S_HDR_LO) && rx_valid) begin
                r_last_idx <= ADDR_WIDTH'(w_count - COUNT_WIDTH'(1));
            end
            // Index wraps to 0 after the last of 2**ADDR_WIDTH words; the FSM
            // has left DATA by then so no further write follows.
            if (w_word_done) begin
                r_addr <= r_widx;
                r_widx <= r_widx + ADDR_WIDTH'(1);
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Running XOR over header and data bytes of the current frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_xsum <= '0;
        end else if (w_launch) begin
            r_xsum <= '0;
        end else if (rx_valid && ((r_state == S_HDR_HI) || (r_state == S_HDR_LO) || (r_state == S_DATA))) begin
            r_xsum <= r_xsum ^ rx_data;
        end
    end
`endif

    assign ram_data = w_word;
    assign ram_addr = r_addr;
    assign ram_we   = w_word_valid && (r_state != S_ERR);
    assign busy     = w_busy;
    assign cpu_hold = w_busy;
    assign done     = (r_state == S_DONE);
    assign error    = (r_state == S_ERR);

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module  : tb_prog_loader
// Brief   : Self-checking bench for prog_loader. Expected RAM writes are
//           queued before each frame; a negedge monitor pops and compares
//           address, data and the cycle the write appears.
// Options : define PROG_LOADER_CHECKSUM_EN to exercise the checksum frames.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;

    localparam int DW = 32;
    localparam int AW = 6;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          pos;
    } wr_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic          busy;
    logic          done;
    logic          error;
    logic          cpu_hold;

    wr_t sb[$];
    int  sent_cyc [0:1023];
    int  bpos;
    int  cyc;
    int  n_cmp;
    int  n_err;

    logic [7:0] f_two [10] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

    prog_loader #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .ram_data (ram_data),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_hold (cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every ram_we cycle must match the oldest queued write
    always @(negedge clk) begin
        if (ram_we !== 1'b0) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got we=%b addr %0d data %h, required no write",
                         ram_we, ram_addr, ram_data);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 32'(ram_addr), 32'(e.addr));
                check("wr_data", ram_data, e.data);
                check("wr_latency_cycle", 32'(cyc), 32'(sent_cyc[e.pos] + 1));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        sent_cyc[bpos] = cyc;
        bpos++;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Checksum byte exists only when the feature is built in
    task automatic send_chk(input logic [7:0] b);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(b);
`else
        if (b === 8'hxx) idle(1);
`endif
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bpos  = 0;
    endtask

    task automatic expect_wr(input int a, input logic [31:0] d, input int p);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.pos  = p;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        bpos = 0; n_cmp = 0; n_err = 0; cyc = 0;
        idle(3);
        check("rst_we", 32'(ram_we), 0);
        check("rst_addr", 32'(ram_addr), 0);
        check("rst_data", ram_data, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_hold", 32'(cpu_hold), 0);
        rst_n = 1'b1;
        idle(1);

        // N=2 with idle gaps between bytes
        start_frame();
        check("start_busy", 32'(busy), 1);
        check("start_hold", 32'(cpu_hold), 1);
        expect_wr(0, 32'h12345678, 5);
        expect_wr(1, 32'h9ABCDEF0, 9);
        foreach (f_two[i]) begin
            send_byte(f_two[i]);
            idle(2);
        end
        send_chk(8'h02);
        idle(3);
        check("n2_done", 32'(done), 1);
        check("n2_busy", 32'(busy), 0);
        check("n2_hold", 32'(cpu_hold), 0);
        check("n2_error", 32'(error), 0);
        check("n2_sb_empty", 32'(sb.size()), 0);

        // Same frame, rx_valid every cycle
        start_frame();
        check("b2b_done_cleared", 32'(done), 0);
        expect_wr(0, 32'h12345678, 5);
        expect_wr(1, 32'h9ABCDEF0, 9);
        foreach (f_two[i]) send_byte(f_two[i]);
        send_chk(8'h02);
        idle(3);
        check("b2b_done", 32'(done), 1);
        check("b2b_addr_hold", 32'(ram_addr), 1);
        check("b2b_sb_empty", 32'(sb.size()), 0);

        // N=0: nothing written
        start_frame();
        send_byte(8'h00);
        send_byte(8'h00);
        send_chk(8'h00);
        idle(3);
        check("n0_done", 32'(done), 1);
        check("n0_busy", 32'(busy), 0);

        // N=65 exceeds 64-word RAM; trailing bytes ignored
        start_frame();
        send_byte(8'h00);
        send_byte(8'h41);
        idle(1);
        check("big_error", 32'(error), 1);
        check("big_busy", 32'(busy), 0);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        idle(3);
        check("big_error_sticky", 32'(error), 1);
        check("big_done", 32'(done), 0);

        // N=64 fills the RAM exactly; checksum of 40 plus bytes 00..FF is 40
        start_frame();
        check("full_error_cleared", 32'(error), 0);
        for (int k = 0; k < 64; k++) begin
            expect_wr(k, {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)}, 2 + 4*k + 3);
        end
        send_byte(8'h00);
        send_byte(8'h40);
        for (int k = 0; k < 256; k++) send_byte(8'(k));
        send_chk(8'h40);
        idle(3);
        check("full_done", 32'(done), 1);
        check("full_last_addr", 32'(ram_addr), 63);
        check("full_sb_empty", 32'(sb.size()), 0);

        // Stall after 5 data bytes: timeout 100 cycles after last byte edge
        start_frame();
        expect_wr(0, 32'h11223344, 5);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55);
        idle(50);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("tmo_start_ignored_busy", 32'(busy), 1);
        check("tmo_start_ignored_err", 32'(error), 0);
        idle(48);
        check("tmo_not_yet", 32'(error), 0);
        check("tmo_busy_before", 32'(busy), 1);
        idle(1);
        check("tmo_error", 32'(error), 1);
        check("tmo_busy", 32'(busy), 0);
        check("tmo_hold", 32'(cpu_hold), 0);
        check("tmo_sb_empty", 32'(sb.size()), 0);

        // Reset during DATA, then a fresh single-word load
        start_frame();
        expect_wr(0, 32'h01020304, 5);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h05);
        idle(1);
        rst_n = 1'b0;
        idle(2);
        check("mid_rst_we", 32'(ram_we), 0);
        check("mid_rst_addr", 32'(ram_addr), 0);
        check("mid_rst_data", ram_data, 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_error", 32'(error), 0);
        check("mid_rst_hold", 32'(cpu_hold), 0);
        rst_n = 1'b1;
        idle(1);
        start_frame();
        expect_wr(0, 32'hAABBCCDD, 5);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        send_chk(8'h01);
        idle(3);
        check("post_rst_done", 32'(done), 1);
        check("post_rst_addr", 32'(ram_addr), 0);
        check("post_rst_sb_empty", 32'(sb.size()), 0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // XOR of 00 01 01 02 03 04 is 05
        start_frame();
        expect_wr(0, 32'h01020304, 5);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h05);
        idle(2);
        check("chk_good_done", 32'(done), 1);
        check("chk_good_error", 32'(error), 0);
        start_frame();
        expect_wr(0, 32'h01020304, 5);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h04);
        idle(2);
        check("chk_bad_error", 32'(error), 1);
        check("chk_bad_done", 32'(done), 0);
        check("chk_sb_empty", 32'(sb.size()), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
